sd_init_ctrl: RTL and testbench

Sequencer that drives the single-command SD engine (SPI-mode command/response/data block) through card power-up and initialization, then serves single-block read requests from the host logic. It owns the engine's `cmd_number`/`cmd_args`/`cmd_crc`/`start` inputs and interprets its `done`/`response_flags`/`data_transmission` outputs. It sits between the SD command engine and the game/host-side memory logic, and is the only client of the engine.

---
 rtl/sd_init_ctrl_if.sv | 20 ++
 rtl/sd_init_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_sd_init_ctrl.sv | 500 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_init_ctrl_if.sv
// Command bus between the init sequencer (master) and the single-command SD engine (slave).
interface sd_init_ctrl_if;
    logic [7:0]  cmd_number;
    logic [31:0] cmd_args;
    logic [7:0]  cmd_crc;
    logic        cmd_start;
    logic        cmd_done;
    logic [7:0]  cmd_response;
    logic [31:0] cmd_data;

    modport master (
        output cmd_number, cmd_args, cmd_crc, cmd_start,
        input  cmd_done, cmd_response, cmd_data
    );

    modport slave (
        input  cmd_number, cmd_args, cmd_crc, cmd_start,
        output cmd_done, cmd_response, cmd_data
    );
endinterface

// File: rtl/sd_init_ctrl.sv
// SD card power-up / SPI-mode initialization sequencer and single-block read server.
// Optional feature macro: SD_INIT_CTRL_CMD8_EN adds the CMD8 (SDv2/SDHC) step.
// The ACMD41 retry counter is 8 bits wide, so ACMD41_RETRIES must not exceed 255.
module sd_init_ctrl #(
    parameter int unsigned POWERUP_CYCLES = 80,
    parameter int unsigned CMD0_RETRIES   = 8,
    parameter int unsigned ACMD41_RETRIES = 255,
    parameter int unsigned CMD_TIMEOUT    = 2048
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init_start,
    sd_init_ctrl_if.master        eng,
    input  logic                  rd_req,
    input  logic [31:0]           rd_addr,
    output logic                  cs_n,
    output logic                  busy,
    output logic                  init_done,
    output logic                  init_err,
    output logic                  rd_ready,
    output logic                  rd_valid,
    output logic [31:0]           rd_data,
    output logic                  rd_err
);

    typedef enum logic [3:0] {
        StIdle,
        StPwrup,
        StCmd0,
`ifdef SD_INIT_CTRL_CMD8_EN
        StCmd8,
`endif
        StCmd55,
        StAcmd41,
        StCmd16,
        StReady,
        StRead,
        StError
    } state_t;

    localparam logic [15:0] PwrupLast = 16'(POWERUP_CYCLES - 1);
    localparam logic [15:0] WdLast    = 16'(CMD_TIMEOUT - 1);
    localparam logic [7:0]  Cmd0Last  = 8'(CMD0_RETRIES - 1);
    localparam logic [7:0]  AcmdMax   = 8'(ACMD41_RETRIES);

    state_t      state;
    logic [15:0] tick;     // power-up count, then per-command watchdog
    logic [7:0]  retry;    // CMD0 failures, later ACMD41 busy replies
    logic [31:0] addr;
    logic        v2;

    logic        cmd_start;
    logic [7:0]  cmd_number;
    logic [31:0] cmd_args;
    logic [7:0]  cmd_crc;

    logic [7:0]  num_c;
    logic [31:0] arg_c;
    logic [7:0]  crc_c;

    assign eng.cmd_start  = cmd_start;
    assign eng.cmd_number = cmd_number;
    assign eng.cmd_args   = cmd_args;
    assign eng.cmd_crc    = cmd_crc;

`ifndef SD_INIT_CTRL_CMD8_EN
    assign v2 = 1'b0;
`endif

    // Command fields for the current state; latched into the outputs when the command starts.
    always_comb begin
        num_c = 8'h40;
        arg_c = 32'h0;
        crc_c = 8'hFF;
        case (state)
            StCmd0:   crc_c = 8'h95;
`ifdef SD_INIT_CTRL_CMD8_EN
            StCmd8: begin
                num_c = 8'h48;
                arg_c = 32'h0000_01AA;
                crc_c = 8'h87;
            end
`endif
            StCmd55:  num_c = 8'h77;
            StAcmd41: begin
                num_c = 8'h69;
                arg_c = v2 ? 32'h4000_0000 : 32'h0;
            end
            StCmd16: begin
                num_c = 8'h50;
                arg_c = 32'h0000_0200;
            end
            StRead: begin
                num_c = 8'h51;
                arg_c = addr;
            end
            default: ;
        endcase
    end

    task automatic go_error();
        state     <= StError;
        cmd_start <= 1'b0;
        cs_n      <= 1'b1;
        busy      <= 1'b0;
        init_done <= 1'b0;
        rd_ready  <= 1'b0;
        init_err  <= 1'b1;
    endtask

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            tick       <= 16'h0;
            retry      <= 8'h0;
            addr       <= 32'h0;
`ifdef SD_INIT_CTRL_CMD8_EN
            v2         <= 1'b0;
`endif
            cmd_start  <= 1'b0;
            cmd_number <= 8'h40;
            cmd_args   <= 32'h0;
            cmd_crc    <= 8'hFF;
            cs_n       <= 1'b1;
            busy       <= 1'b0;
            init_done  <= 1'b0;
            init_err   <= 1'b0;
            rd_ready   <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= 32'h0;
            rd_err     <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
            case (state)
                StIdle: begin
                    if (init_start) begin
                        state <= StPwrup;
                        busy  <= 1'b1;
                        tick  <= 16'h0;
                    end
                end
                StPwrup: begin
                    if (tick == PwrupLast) begin
                        state <= StCmd0;
                        cs_n  <= 1'b0;
                        retry <= 8'h0;
                    end else begin
                        tick <= tick + 16'd1;
                    end
                end
                StReady: begin
                    if (rd_req) begin
                        addr     <= rd_addr;
                        state    <= StRead;
                        busy     <= 1'b1;
                        rd_ready <= 1'b0;
                    end
                end
                StError: ;
                default: begin
                    // Command states: start low means this is the first cycle in the state.
                    if (!cmd_start) begin
                        cmd_start  <= 1'b1;
                        cmd_number <= num_c;
                        cmd_args   <= arg_c;
                        cmd_crc    <= crc_c;
                        tick       <= 16'h0;
                    end else if (eng.cmd_done) begin
                        // Done has priority over a simultaneous watchdog expiry.
                        cmd_start <= 1'b0;
                        case (state)
                            StCmd0: begin
                                if (eng.cmd_response == 8'h01) begin
                                    retry <= 8'h0;
`ifdef SD_INIT_CTRL_CMD8_EN
                                    state <= StCmd8;
`else
                                    state <= StCmd55;
`endif
                                end else if (retry == Cmd0Last) begin
                                    go_error();
                                end else begin
                                    retry <= retry + 8'd1;
                                end
                            end
`ifdef SD_INIT_CTRL_CMD8_EN
                            StCmd8: begin
                                if (eng.cmd_response == 8'h01) begin
                                    v2    <= 1'b1;
                                    state <= StCmd55;
                                end else if (eng.cmd_response == 8'h05) begin
                                    v2    <= 1'b0;
                                    state <= StCmd55;
                                end else begin
                                    go_error();
                                end
                            end
`endif
                            StCmd55: begin
                                if (eng.cmd_response == 8'h00 || eng.cmd_response == 8'h01) begin
                                    state <= StAcmd41;
                                end else begin
                                    go_error();
                                end
                            end
                            StAcmd41: begin
                                if (eng.cmd_response == 8'h00) begin
                                    state <= StCmd16;
                                end else if (eng.cmd_response == 8'h01 &&
                                             (retry + 8'd1) != AcmdMax) begin
                                    retry <= retry + 8'd1;
                                    state <= StCmd55;
                                end else begin
                                    go_error();
                                end
                            end
                            StCmd16: begin
                                if (eng.cmd_response == 8'h00) begin
                                    state     <= StReady;
                                    busy      <= 1'b0;
                                    init_done <= 1'b1;
                                    rd_ready  <= 1'b1;
                                end else begin
                                    go_error();
                                end
                            end
                            StRead: begin
                                if (eng.cmd_response == 8'h00) begin
                                    rd_data  <= eng.cmd_data;
                                    rd_valid <= 1'b1;
                                end else begin
                                    rd_err <= 1'b1;
                                end
                                state    <= StReady;
                                busy     <= 1'b0;
                                rd_ready <= 1'b1;
                            end
                            default: go_error();
                        endcase
                    end else if (tick == WdLast) begin
                        go_error();
                    end else begin
                        tick <= tick + 16'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_init_ctrl.sv
// Directed bench for sd_init_ctrl with a behavioural SD command engine.
module tb_sd_init_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        init_start;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        cs_n, busy, init_done, init_err, rd_ready, rd_valid, rd_err;
    logic [31:0] rd_data;

    sd_init_ctrl_if eng_if ();

    sd_init_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .init_start (init_start),
        .eng        (eng_if),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .cs_n       (cs_n),
        .busy       (busy),
        .init_done  (init_done),
        .init_err   (init_err),
        .rd_ready   (rd_ready),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_err     (rd_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Engine model configuration and command log.
    logic [7:0]  r_cmd0, r_cmd8, r_cmd55, r_cmd16, r_read;
    int          acmd_busy;
    int          acmd_seen;
    bit          mute16;
    logic [31:0] read_data;
    logic [7:0]  log_num [64];
    logic [31:0] log_arg [64];
    int          log_n;

    // Engine: answers each command 3 negedges after cmd_start rises, done held one cycle.
    initial begin
        bit         active;
        bit         last;
        int         wait_n;
        logic [7:0] resp;
        active = 0;
        last   = 0;
        wait_n = 0;
        log_n  = 0;
        acmd_seen = 0;
        eng_if.cmd_done     = 1'b0;
        eng_if.cmd_response = 8'hFF;
        eng_if.cmd_data     = 32'h0;
        forever begin
            @(negedge clk);
            eng_if.cmd_done = 1'b0;
            if (reset) begin
                active    = 0;
                last      = 0;
                log_n     = 0;
                acmd_seen = 0;
            end else begin
                if (eng_if.cmd_start && !last) begin
                    if (log_n < 64) begin
                        log_num[log_n] = eng_if.cmd_number;
                        log_arg[log_n] = eng_if.cmd_args;
                    end
                    log_n++;
                    active = !(mute16 && eng_if.cmd_number == 8'h50);
                    wait_n = 2;
                end
                if (!eng_if.cmd_start) active = 0;
                if (active) begin
                    if (wait_n == 0) begin
                        case (eng_if.cmd_number)
                            8'h40: resp = r_cmd0;
                            8'h48: resp = r_cmd8;
                            8'h77: resp = r_cmd55;
                            8'h69: begin
                                resp = (acmd_seen < acmd_busy) ? 8'h01 : 8'h00;
                                acmd_seen++;
                            end
                            8'h50: resp = r_cmd16;
                            8'h51: resp = r_read;
                            default: resp = 8'hFF;
                        endcase
                        eng_if.cmd_done     = 1'b1;
                        eng_if.cmd_response = resp;
                        eng_if.cmd_data     = read_data;
                        active = 0;
                    end else begin
                        wait_n--;
                    end
                end
                last = eng_if.cmd_start;
            end
        end
    end

    task automatic do_reset();
        reset      = 1'b1;
        init_start = 1'b0;
        rd_req     = 1'b0;
        rd_addr    = 32'h0;
        r_cmd0     = 8'h01;
        r_cmd8     = 8'h01;
        r_cmd55    = 8'h01;
        r_cmd16    = 8'h00;
        r_read     = 8'h00;
        acmd_busy  = 2;
        mute16     = 0;
        read_data  = 32'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    // Raise init_start and count clocks until the first cmd_start.
    task automatic measure_pwrup(output int lat, output logic cs_at80);
        @(negedge clk);
        init_start = 1'b1;
        lat = 0;
        cs_at80 = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 80) cs_at80 = cs_n;
            if (eng_if.cmd_start) break;
        end
        init_start = 1'b0;
    endtask

    task automatic wait_init(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (init_done || init_err) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        init_start = 1'b0;
        rd_req = 1'b0;
        rd_addr = 32'h0;
        #3;
        total++;
        if ({eng_if.cmd_start, cs_n, busy, init_done, init_err, rd_ready, rd_valid, rd_err}
            !== 8'b0100_0000) begin
            bad++;
            $display("FAIL reset_flags: got %b want 01000000",
                     {eng_if.cmd_start, cs_n, busy, init_done, init_err, rd_ready, rd_valid,
                      rd_err});
        end
        total++;
        if (eng_if.cmd_number !== 8'h40) begin
            bad++;
            $display("FAIL reset_cmd_number: got %h want 40", eng_if.cmd_number);
        end
        total++;
        if (eng_if.cmd_args !== 32'h0) begin
            bad++;
            $display("FAIL reset_cmd_args: got %h want 0", eng_if.cmd_args);
        end
        total++;
        if (eng_if.cmd_crc !== 8'hFF) begin
            bad++;
            $display("FAIL reset_cmd_crc: got %h want ff", eng_if.cmd_crc);
        end
        total++;
        if (rd_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_rd_data: got %h want 0", rd_data);
        end
        do_reset();
        repeat (10) @(posedge clk);
        #1;
        total++;
        if ({busy, eng_if.cmd_start, cs_n} !== 3'b001) begin
            bad++;
            $display("FAIL idle_hold: got %b want 001", {busy, eng_if.cmd_start, cs_n});
        end
    endtask

    task automatic test_nominal();
        int         lat;
        logic       cs80;
        bit         ok;
        logic [7:0] exp_seq [9];
        int         n;
        int         ai;
        logic [31:0] exp_arg;
        do_reset();
        measure_pwrup(lat, cs80);
        total++;
        if (lat !== 82) begin
            bad++;
            $display("FAIL pwrup_latency: got %0d want 82", lat);
        end
        total++;
        if (cs80 !== 1'b1) begin
            bad++;
            $display("FAIL pwrup_cs_high: got %b want 1", cs80);
        end
        total++;
        if ({cs_n, busy, eng_if.cmd_number, eng_if.cmd_crc} !== {1'b0, 1'b1, 8'h40, 8'h95}) begin
            bad++;
            $display("FAIL cmd0_issue: got cs_n=%b busy=%b num=%h crc=%h want 0 1 40 95",
                     cs_n, busy, eng_if.cmd_number, eng_if.cmd_crc);
        end
        wait_init(2000, ok);
        total++;
        if ({ok, init_done, init_err, rd_ready, busy} !== 5'b11010) begin
            bad++;
            $display("FAIL init_done_state: got ok=%b done=%b err=%b rdy=%b busy=%b want 1 1 0 1 0",
                     ok, init_done, init_err, rd_ready, busy);
        end
`ifdef SD_INIT_CTRL_CMD8_EN
        exp_seq = '{8'h40, 8'h48, 8'h77, 8'h69, 8'h77, 8'h69, 8'h77, 8'h69, 8'h50};
        n = 9;
        ai = 3;
        exp_arg = 32'h4000_0000;
        total++;
        if (log_arg[1] !== 32'h0000_01AA) begin
            bad++;
            $display("FAIL cmd8_arg: got %h want 000001aa", log_arg[1]);
        end
`else
        exp_seq = '{8'h40, 8'h77, 8'h69, 8'h77, 8'h69, 8'h77, 8'h69, 8'h50, 8'h00};
        n = 8;
        ai = 2;
        exp_arg = 32'h0;
`endif
        total++;
        if (log_n !== n) begin
            bad++;
            $display("FAIL nominal_cmd_count: got %0d want %0d", log_n, n);
        end
        for (int i = 0; i < n; i++) begin
            total++;
            if (log_num[i] !== exp_seq[i]) begin
                bad++;
                $display("FAIL nominal_seq[%0d]: got %h want %h", i, log_num[i], exp_seq[i]);
            end
        end
        total++;
        if (log_arg[ai] !== exp_arg) begin
            bad++;
            $display("FAIL acmd41_arg: got %h want %h", log_arg[ai], exp_arg);
        end
        total++;
        if (log_arg[n-1] !== 32'h0000_0200) begin
            bad++;
            $display("FAIL cmd16_arg: got %h want 00000200", log_arg[n-1]);
        end
    endtask

    // Runs from READY left by test_nominal.
    task automatic test_read();
        bit got;
        @(negedge clk);
        rd_addr   = 32'h0000_1234;
        rd_req    = 1'b1;
        read_data = 32'hDEAD_BEEF;
        r_read    = 8'h00;
        @(posedge clk);
        #1;
        total++;
        if ({rd_ready, busy} !== 2'b01) begin
            bad++;
            $display("FAIL rd_accept: got rdy=%b busy=%b want 0 1", rd_ready, busy);
        end
        @(negedge clk);
        rd_req  = 1'b0;
        rd_addr = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        total++;
        if ({eng_if.cmd_start, eng_if.cmd_number, eng_if.cmd_args} !==
            {1'b1, 8'h51, 32'h0000_1234}) begin
            bad++;
            $display("FAIL read_cmd: got start=%b num=%h arg=%h want 1 51 00001234",
                     eng_if.cmd_start, eng_if.cmd_number, eng_if.cmd_args);
        end
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (rd_valid) begin
                got = 1;
                break;
            end
        end
        total++;
        if ({got, eng_if.cmd_done, rd_data} !== {1'b1, 1'b1, 32'hDEAD_BEEF}) begin
            bad++;
            $display("FAIL rd_valid_data: got seen=%b done=%b data=%h want 1 1 deadbeef",
                     got, eng_if.cmd_done, rd_data);
        end
        @(posedge clk);
        #1;
        total++;
        if ({rd_valid, rd_ready} !== 2'b01) begin
            bad++;
            $display("FAIL rd_valid_pulse: got valid=%b rdy=%b want 0 1", rd_valid, rd_ready);
        end
        @(negedge clk);
        rd_addr = 32'h0000_5678;
        rd_req  = 1'b1;
        r_read  = 8'h04;
        read_data = 32'h1111_2222;
        @(negedge clk);
        rd_req = 1'b0;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (rd_err) begin
                got = 1;
                break;
            end
        end
        total++;
        if ({got, rd_valid, rd_data} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
            bad++;
            $display("FAIL rd_err_pulse: got seen=%b valid=%b data=%h want 1 0 deadbeef",
                     got, rd_valid, rd_data);
        end
        @(posedge clk);
        #1;
        total++;
        if ({rd_err, rd_ready, init_err, init_done} !== 4'b0101) begin
            bad++;
            $display("FAIL rd_err_return: got err=%b rdy=%b ierr=%b idone=%b want 0 1 0 1",
                     rd_err, rd_ready, init_err, init_done);
        end
    endtask

    task automatic test_cmd0_fail();
        bit ok;
        int c0;
        do_reset();
        r_cmd0 = 8'hFF;
        @(negedge clk);
        init_start = 1'b1;
        wait_init(3000, ok);
        init_start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        c0 = 0;
        for (int i = 0; i < 64; i++) if (i < log_n && log_num[i] == 8'h40) c0++;
        total++;
        if ({ok, c0, log_n} !== {1'b1, 32'd8, 32'd8}) begin
            bad++;
            $display("FAIL cmd0_retries: got done=%b cmd0=%0d total=%0d want 1 8 8", ok, c0, log_n);
        end
        total++;
        if ({init_err, cs_n, eng_if.cmd_start, init_done, busy} !== 5'b11000) begin
            bad++;
            $display("FAIL cmd0_error_state: got %b want 11000",
                     {init_err, cs_n, eng_if.cmd_start, init_done, busy});
        end
    endtask

    task automatic test_cmd8_05();
        bit ok;
        int ai;
        do_reset();
        r_cmd8 = 8'h05;
        @(negedge clk);
        init_start = 1'b1;
        wait_init(2000, ok);
        init_start = 1'b0;
        total++;
        if ({ok, init_done} !== 2'b11) begin
            bad++;
            $display("FAIL cmd8_05_init: got ok=%b done=%b want 1 1", ok, init_done);
        end
`ifdef SD_INIT_CTRL_CMD8_EN
        total++;
        if (log_num[1] !== 8'h48) begin
            bad++;
            $display("FAIL after_cmd0: got %h want 48", log_num[1]);
        end
        ai = 3;
`else
        total++;
        if (log_num[1] !== 8'h77) begin
            bad++;
            $display("FAIL after_cmd0: got %h want 77", log_num[1]);
        end
        ai = 2;
`endif
        total++;
        if ({log_num[ai], log_arg[ai]} !== {8'h69, 32'h0}) begin
            bad++;
            $display("FAIL acmd41_arg_v1: got num=%h arg=%h want 69 00000000",
                     log_num[ai], log_arg[ai]);
        end
    endtask

    task automatic test_watchdog();
        bit found;
        int cnt;
        do_reset();
        mute16 = 1;
        @(negedge clk);
        init_start = 1'b1;
        found = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (eng_if.cmd_start && eng_if.cmd_number == 8'h50) begin
                found = 1;
                break;
            end
        end
        init_start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!found) break;
            @(posedge clk);
            #1;
            cnt++;
            if (!eng_if.cmd_start) break;
        end
        total++;
        if ({found, cnt} !== {1'b1, 32'd2048}) begin
            bad++;
            $display("FAIL watchdog_len: got found=%b cycles=%0d want 1 2048", found, cnt);
        end
        total++;
        if ({init_err, cs_n, busy, init_done} !== 4'b1100) begin
            bad++;
            $display("FAIL watchdog_error: got %b want 1100", {init_err, cs_n, busy, init_done});
        end
    endtask

    task automatic test_reset_mid();
        bit   found;
        int   lat;
        logic cs80;
        do_reset();
        acmd_busy = 100;
        @(negedge clk);
        init_start = 1'b1;
        found = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (eng_if.cmd_start && eng_if.cmd_number == 8'h69) begin
                found = 1;
                break;
            end
        end
        init_start = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({found, eng_if.cmd_start, cs_n, busy} !== 4'b1010) begin
            bad++;
            $display("FAIL reset_async: got found=%b start=%b cs_n=%b busy=%b want 1 0 1 0",
                     found, eng_if.cmd_start, cs_n, busy);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        measure_pwrup(lat, cs80);
        total++;
        if ({lat, cs80, eng_if.cmd_number} !== {32'd82, 1'b1, 8'h40}) begin
            bad++;
            $display("FAIL reinit_pwrup: got lat=%0d cs80=%b num=%h want 82 1 40",
                     lat, cs80, eng_if.cmd_number);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_read();
        test_cmd0_fail();
        test_cmd8_05();
        test_watchdog();
        test_reset_mid();
        do_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
